// File: rtl/ram_host_arb.sv
// Round-robin arbiter that gives NumHosts hosts access to a single-port 32-bit RAM.
// Responses come back one cycle after the grant; out-of-range accesses are answered locally with an error.
module ram_host_arb #(
   parameter int unsigned NumHosts = 2,
   parameter int unsigned Depth    = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumHosts-1:0]      host_req_i,
   output logic [NumHosts-1:0]      host_gnt_o,
   input  logic [NumHosts-1:0]      host_we_i,
   input  logic [4*NumHosts-1:0]    host_be_i,
   input  logic [32*NumHosts-1:0]   host_addr_i,
   input  logic [32*NumHosts-1:0]   host_wdata_i,
   output logic [NumHosts-1:0]      host_rvalid_o,
   output logic [NumHosts-1:0]      host_err_o,
   output logic [31:0]              host_rdata_o,
   output logic                     ram_req_o,
   output logic                     ram_we_o,
   output logic [3:0]               ram_be_o,
   output logic [31:0]              ram_addr_o,
   output logic [31:0]              ram_wdata_o,
   input  logic                     ram_rvalid_i,
   input  logic [31:0]              ram_rdata_i
);

   localparam int unsigned Aw   = $clog2(Depth);
   localparam int unsigned IdxW = $clog2(NumHosts);

   logic [IdxW-1:0]     last_q;
   logic [IdxW-1:0]     gnt_idx;
   logic                gnt_any;
   logic [NumHosts-1:0] gnt;

   logic                sel_we;
   logic [3:0]          sel_be;
   logic [31:0]         sel_addr;
   logic [31:0]         sel_wdata;
   logic                sel_oob;

   logic                pend_q;
   logic [IdxW-1:0]     pend_idx_q;
   logic                pend_oob_q;

   // Search starts one past the last winner; the modulo wrap is done by a single subtract.
   always_comb begin : arb
      logic [IdxW:0] cand;
      cand    = '0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned i = 1; i <= NumHosts; i++) begin
         cand = {1'b0, last_q} + (IdxW+1)'(i);
         if (cand >= (IdxW+1)'(NumHosts)) begin
            cand = cand - (IdxW+1)'(NumHosts);
         end
         if (!gnt_any && host_req_i[cand[IdxW-1:0]]) begin
            gnt_any                 = 1'b1;
            gnt_idx                 = cand[IdxW-1:0];
            gnt[cand[IdxW-1:0]]     = 1'b1;
         end
      end
   end

   always_comb begin : attr_mux
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned k = 0; k < NumHosts; k++) begin
         if (gnt[k]) begin
            sel_we    = host_we_i[k];
            sel_be    = host_be_i[4*k +: 4];
            sel_addr  = host_addr_i[32*k +: 32];
            sel_wdata = host_wdata_i[32*k +: 32];
         end
      end
   end

   assign sel_oob     = (sel_addr >> (Aw + 2)) != '0;
   assign host_gnt_o  = gnt;
   assign ram_req_o   = gnt_any & ~sel_oob;
   assign ram_we_o    = sel_we;
   assign ram_be_o    = sel_be;
   assign ram_addr_o  = sel_addr;
   assign ram_wdata_o = sel_wdata;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q     <= IdxW'(NumHosts - 1);
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         pend_oob_q <= 1'b0;
      end else begin
         pend_q     <= gnt_any;
         pend_idx_q <= gnt_idx;
         pend_oob_q <= sel_oob;
         if (gnt_any) begin
            last_q <= gnt_idx;
         end
      end
   end

   always_comb begin : resp
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      if (pend_q) begin
         host_rvalid_o[pend_idx_q] = 1'b1;
         if (pend_oob_q) begin
            host_err_o[pend_idx_q] = 1'b1;
         end else begin
            host_rdata_o = ram_rdata_i;
         end
      end
   end

   // The RAM is trusted to answer exactly the in-range grants; only simulation checks it.
   rvalid_match_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ram_rvalid_i == (pend_q && !pend_oob_q));

endmodule

// File: tb/tb_ram_host_arb.sv
// Randomized bench for ram_host_arb: a behavioural arbiter/memory model predicts grants and
// responses; expected responses are queued and checked by an independent monitor.
module tb_ram_host_arb;

   localparam int NH    = 2;
   localparam int DEPTH = 128;

   logic                clk_i = 1'b0;
   logic                rst_ni = 1'b0;
   logic [NH-1:0]       host_req_i = '0;
   logic [NH-1:0]       host_gnt_o;
   logic [NH-1:0]       host_we_i = '0;
   logic [4*NH-1:0]     host_be_i = '0;
   logic [32*NH-1:0]    host_addr_i = '0;
   logic [32*NH-1:0]    host_wdata_i = '0;
   logic [NH-1:0]       host_rvalid_o;
   logic [NH-1:0]       host_err_o;
   logic [31:0]         host_rdata_o;
   logic                ram_req_o;
   logic                ram_we_o;
   logic [3:0]          ram_be_o;
   logic [31:0]         ram_addr_o;
   logic [31:0]         ram_wdata_o;
   logic                ram_rvalid_i = 1'b0;
   logic [31:0]         ram_rdata_i = '0;

   ram_host_arb #(
      .NumHosts (NH),
      .Depth    (DEPTH)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .host_req_i    (host_req_i),
      .host_gnt_o    (host_gnt_o),
      .host_we_i     (host_we_i),
      .host_be_i     (host_be_i),
      .host_addr_i   (host_addr_i),
      .host_wdata_i  (host_wdata_i),
      .host_rvalid_o (host_rvalid_o),
      .host_err_o    (host_err_o),
      .host_rdata_o  (host_rdata_o),
      .ram_req_o     (ram_req_o),
      .ram_we_o      (ram_we_o),
      .ram_be_o      (ram_be_o),
      .ram_addr_o    (ram_addr_o),
      .ram_wdata_o   (ram_wdata_o),
      .ram_rvalid_i  (ram_rvalid_i),
      .ram_rdata_i   (ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int unsigned cyc;
      int          host;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] ram_mem [DEPTH];
   logic [31:0] gm      [DEPTH];
   bit          ram_init_done = 1'b0;
   int          m_last = NH - 1;

   logic        h_we    [NH];
   logic [3:0]  h_be    [NH];
   logic [31:0] h_addr  [NH];
   logic [31:0] h_wdata [NH];

   function automatic logic [31:0] init_word(int i);
      return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be, logic we);
      logic [31:0] r;
      r = old;
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
         end
      end
      return r;
   endfunction

   function automatic int pick(logic [NH-1:0] req);
      for (int i = 1; i <= NH; i++) begin
         int h;
         h = (m_last + i) % NH;
         if (req[h]) return h;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Bench RAM: one-cycle latency, returns the word as it stands after the access.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ram_rvalid_i <= 1'b0;
         if (!ram_init_done) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
         end
      end else begin
         ram_rvalid_i <= ram_req_o;
         if (ram_req_o) begin
            ram_mem[(ram_addr_o >> 2) % DEPTH] <=
               merge(ram_mem[(ram_addr_o >> 2) % DEPTH], ram_wdata_o, ram_be_o, ram_we_o);
            ram_rdata_i <=
               merge(ram_mem[(ram_addr_o >> 2) % DEPTH], ram_wdata_o, ram_be_o, ram_we_o);
         end
      end
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: every cycle the response outputs must match the queue head due now, else be idle.
   always @(negedge clk_i) begin : mon
      logic [NH-1:0] ev;
      logic [NH-1:0] ee;
      logic [31:0]   ed;
      exp_t          e;
      ev = '0;
      ee = '0;
      ed = '0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         failures++;
         $display("FAIL stale_response host %0d due cycle %0d, now %0d", q[0].host, q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         ev[e.host] = 1'b1;
         if (e.err) ee[e.host] = 1'b1;
         ed = e.rdata;
      end
      chk("rvalid", 32'(host_rvalid_o), 32'(ev));
      chk("err",    32'(host_err_o),    32'(ee));
      chk("rdata",  host_rdata_o,       ed);
   end

   // One bus cycle: called just after a rising edge, returns just after the next one.
   task automatic tick(input logic [NH-1:0] req);
      int            w;
      logic [NH-1:0] eg;
      logic [31:0]   a;
      bit            inr;
      int            idx;
      exp_t          e;
      host_req_i = req;
      for (int k = 0; k < NH; k++) begin
         host_we_i[k]             = h_we[k];
         host_be_i[4*k +: 4]      = h_be[k];
         host_addr_i[32*k +: 32]  = h_addr[k];
         host_wdata_i[32*k +: 32] = h_wdata[k];
      end
      @(negedge clk_i);
      w  = pick(req);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", 32'(host_gnt_o), 32'(eg));
      if (w >= 0) begin
         a   = h_addr[w];
         inr = a < 32'(4 * DEPTH);
         chk("ram_req", 32'(ram_req_o), 32'(inr));
         e.cyc  = cyc + 1;
         e.host = w;
         e.err  = !inr;
         e.rdata = '0;
         if (inr) begin
            chk("ram_addr",  ram_addr_o,      a);
            chk("ram_we",    32'(ram_we_o),   32'(h_we[w]));
            chk("ram_be",    32'(ram_be_o),   32'(h_be[w]));
            chk("ram_wdata", ram_wdata_o,     h_wdata[w]);
            idx     = int'(a >> 2);
            gm[idx] = merge(gm[idx], h_wdata[w], h_be[w], h_we[w]);
            e.rdata = gm[idx];
         end
         q.push_back(e);
         m_last = w;
      end else begin
         chk("ram_req_idle", 32'(ram_req_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_host(input int k, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
      h_we[k]    = we;
      h_be[k]    = be;
      h_addr[k]  = addr;
      h_wdata[k] = wdata;
   endtask

   task automatic do_reset(input int n);
      rst_ni     = 1'b0;
      host_req_i = '0;
      q.delete();
      m_last     = NH - 1;
      repeat (n) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) gm[i] = init_word(i);
      for (int k = 0; k < NH; k++) set_host(k, 1'b0, 4'hF, 32'h0, 32'h0);
      do_reset(3);
      tick('0);

      // Simultaneous reads of address 0, then sustained contention.
      set_host(0, 1'b0, 4'hF, 32'h0, 32'h0);
      set_host(1, 1'b0, 4'hF, 32'h0, 32'h0);
      tick(2'b11);
      tick(2'b11);
      tick('0);
      repeat (6) tick(2'b11);
      tick('0);

      // Write from host 1 then read-back by host 0.
      set_host(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      tick(2'b10);
      set_host(0, 1'b0, 4'hF, 32'h10, 32'h0);
      tick(2'b01);

      // Out-of-range read.
      set_host(0, 1'b0, 4'hF, 32'h200, 32'h0);
      tick(2'b01);

      // Partial byte write into a known word, misaligned low address bits.
      set_host(1, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
      tick(2'b10);
      set_host(1, 1'b1, 4'h2, 32'h23, 32'h0000_AB00);
      tick(2'b10);
      set_host(0, 1'b0, 4'hF, 32'h20, 32'h0);
      tick(2'b01);
      tick('0);

      // Reset right after a grant drops its response; host 0 wins first afterwards.
      set_host(1, 1'b0, 4'hF, 32'h4, 32'h0);
      tick(2'b10);
      do_reset(2);
      set_host(0, 1'b0, 4'hF, 32'h8, 32'h0);
      set_host(1, 1'b0, 4'hF, 32'hC, 32'h0);
      tick(2'b11);
      tick('0);

      // Random traffic with occasional out-of-range addresses.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NH; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0)
               a = 32'(4 * DEPTH) + ($urandom & 32'h00FF_FFFF);
            else
               a = (32'($urandom_range(0, DEPTH - 1)) << 2) | ($urandom & 32'h3);
            set_host(k, 1'($urandom), 4'($urandom), a, $urandom);
         end
         tick(NH'($urandom));
      end

      tick('0);
      tick('0);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL leftover_responses got %0d expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
